iter_div_unit: RTL and testbench

- Parametrised multi-cycle integer divider for the EX stage. It replaces the fixed-width, vendor-IP signed/unsigned divider pair and its external wait FSM.
- One shared iterative datapath serves signed and unsigned div/mod. It has valid/ready handshakes on both sides and a pipeline flush for ertn/exceptions.
- It also handles divide-by-zero deterministically, terminates early on special cases, and passes a tag through.

---
 rtl/iter_div_unit_pkg.sv | 21 ++
 rtl/iter_div_unit_step.sv | 38 +++
 rtl/iter_div_unit.sv | 146 ++++++++++++++
 tb/tb_iter_div_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iter_div_unit_pkg.sv
// Shared types and defaults for the iterative integer divider.
// State encoding is one-hot so the controller decodes each state from a single flop.
package iter_div_unit_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_BPC   = 1;
  localparam int DEF_TAG_W = 5;

  typedef enum logic [3:0] {
    DIV_IDLE = 4'b0001,
    DIV_CALC = 4'b0010,
    DIV_FIX  = 4'b0100,
    DIV_DONE = 4'b1000
  } div_state_e;

  // Number of CALC iterations needed to resolve a full quotient.
  function automatic int div_steps(input int width, input int bpc);
    return width / bpc;
  endfunction

endpackage

// File: rtl/iter_div_unit_step.sv
// Combinational core of the divider: BPC chained restoring steps per call.
// The quotient bits shift into the low end of the dividend register as it empties.
module div_iter_step #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] dvd_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] dvd_out
);

  logic [WIDTH-1:0] rem_v;
  logic [WIDTH-1:0] dvd_v;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // NOTE: blocking assignments here model a chain of combinational stages;
  // each loop iteration consumes the previous iteration's result.
  always_comb begin
    rem_v   = rem_in;
    dvd_v   = dvd_in;
    shifted = '0;
    diff    = '0;
    for (int i = 0; i < BPC; i++) begin
      shifted = {rem_v, dvd_v[WIDTH-1]};
      // Two guard bits: the shifted remainder can reach 2*divisor-1.
      diff    = {1'b0, shifted} - {2'b00, dvs};
      dvd_v   = {dvd_v[WIDTH-2:0], ~diff[WIDTH+1]};
      rem_v   = diff[WIDTH+1] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end
  end

  assign rem_out = rem_v;
  assign dvd_out = dvd_v;

endmodule

// File: rtl/iter_div_unit.sv
// Multi-cycle signed/unsigned divider with valid/ready on both sides, flush,
// deterministic divide-by-zero and a tag carried alongside the operation.
module iter_div_unit
  import iter_div_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BPC   = DEF_BPC,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic             busy
);

  localparam int               STEPS = div_steps(WIDTH, BPC);
  localparam int               CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STEPS);

  if (WIDTH < 4 || (WIDTH % 2) != 0 || !(BPC == 1 || BPC == 2 || BPC == 4) ||
      (WIDTH % BPC) != 0) begin : g_bad_params
    $error("iter_div_unit: illegal WIDTH/BPC combination");
  end

  div_state_e       state_q;
  div_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic             quot_neg_q;
  logic             rem_neg_q;
  logic [TAG_W-1:0] tag_q;

  logic             accept;
  logic             div_zero;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_dvd;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             sgn);
    return (sgn && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  // A flush in the same cycle must win over any accept, so it gates ready.
  assign in_ready  = ~flush & ((state_q == DIV_IDLE) |
                               ((state_q == DIV_DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign div_zero  = (in_divisor == '0);
  assign out_valid = (state_q == DIV_DONE);
  assign busy      = (state_q != DIV_IDLE);

  div_iter_step #(
    .WIDTH (WIDTH),
    .BPC   (BPC)
  ) u_step (
    .rem_in  (rem_q),
    .dvd_in  (dvd_q),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .dvd_out (step_dvd)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_IDLE: if (accept) state_d = div_zero ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (cnt_q == '0) state_d = DIV_FIX;
      DIV_FIX:  state_d = DIV_DONE;
      DIV_DONE: begin
        if (accept) begin
          state_d = div_zero ? DIV_DONE : DIV_CALC;
        end else if (out_ready) begin
          state_d = DIV_IDLE;
        end
      end
      default:  state_d = DIV_IDLE;
    endcase
    if (flush) state_d = DIV_IDLE;
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the values present before the clock edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      tag_q      <= '0;
      out_quot   <= '0;
      out_rem    <= '0;
      out_tag    <= '0;
      out_dbz    <= 1'b0;
    end else if (accept) begin
      cnt_q      <= CNT_INIT;
      rem_q      <= '0;
      dvd_q      <= magnitude(in_dividend, in_signed);
      dvs_q      <= magnitude(in_divisor, in_signed);
      quot_neg_q <= in_signed & (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]);
      rem_neg_q  <= in_signed & in_dividend[WIDTH-1];
      tag_q      <= in_tag;
      // Divide-by-zero skips the datapath and publishes its fixed result now.
      if (div_zero) begin
        out_quot <= '1;
        out_rem  <= in_dividend;
        out_tag  <= in_tag;
        out_dbz  <= 1'b1;
      end
    end else if (state_q == DIV_CALC && cnt_q != '0) begin
      rem_q <= step_rem;
      dvd_q <= step_dvd;
      cnt_q <= cnt_q - CNT_W'(1);
    end else if (state_q == DIV_FIX) begin
      out_quot <= quot_neg_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
      out_rem  <= rem_neg_q ? (~rem_q + WIDTH'(1)) : rem_q;
      out_tag  <= tag_q;
      out_dbz  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iter_div_unit.sv
// Directed self-checking bench for iter_div_unit: a 32/1 instance for most
// scenarios plus a 32/4 instance for the radix-16 latency case.
module tb_iter_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic [31:0] in_dividend;
  logic [31:0] in_divisor;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_quot;
  logic [31:0] out_rem;
  logic [4:0]  out_tag;
  logic        out_dbz;
  logic        busy;

  logic        flush4;
  logic        in_valid4;
  logic        in_ready4;
  logic        in_signed4;
  logic [31:0] in_dividend4;
  logic [31:0] in_divisor4;
  logic [4:0]  in_tag4;
  logic        out_valid4;
  logic        out_ready4;
  logic [31:0] out_quot4;
  logic [31:0] out_rem4;
  logic [4:0]  out_tag4;
  logic        out_dbz4;
  logic        busy4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iter_div_unit #(.WIDTH(32), .BPC(1), .TAG_W(5)) u_dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_signed   (in_signed),
    .in_dividend (in_dividend),
    .in_divisor  (in_divisor),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_quot    (out_quot),
    .out_rem     (out_rem),
    .out_tag     (out_tag),
    .out_dbz     (out_dbz),
    .busy        (busy)
  );

  iter_div_unit #(.WIDTH(32), .BPC(4), .TAG_W(5)) u_dut4 (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush4),
    .in_valid    (in_valid4),
    .in_ready    (in_ready4),
    .in_signed   (in_signed4),
    .in_dividend (in_dividend4),
    .in_divisor  (in_divisor4),
    .in_tag      (in_tag4),
    .out_valid   (out_valid4),
    .out_ready   (out_ready4),
    .out_quot    (out_quot4),
    .out_rem     (out_rem4),
    .out_tag     (out_tag4),
    .out_dbz     (out_dbz4),
    .busy        (busy4)
  );

  task automatic check(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Drives one operation for a single cycle; returns 1 ns after the accept edge.
  task automatic issue(input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    in_signed   = sgn;
    in_dividend = a;
    in_divisor  = b;
    in_tag      = tag;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_dividend = 32'hDEAD_BEEF;
    in_divisor  = 32'h0000_0003;
  endtask

  // Counts clock edges after the accept edge until out_valid, bounded.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  int          lat;
  logic [31:0] held_quot;
  logic        seen_valid;

  initial begin
    resetn = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_signed = 1'b0;
    in_dividend = '0; in_divisor = '0; in_tag = '0;
    flush4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0; in_signed4 = 1'b0;
    in_dividend4 = '0; in_divisor4 = '0; in_tag4 = '0;

    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy",      32'(busy),      32'd0);
    check("reset_quot",      out_quot,       32'd0);
    check("reset_rem",       out_rem,        32'd0);
    check("reset_tag",       32'(out_tag),   32'd0);
    check("reset_dbz",       32'(out_dbz),   32'd0);
    check("reset_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;

    // Unsigned 100/7: 34 edges after accept.
    issue(1'b0, 32'd100, 32'd7, 5'd5);
    check("u100_7_busy", 32'(busy), 32'd1);
    wait_result(lat);
    check("u100_7_latency", 32'(lat),      32'd34);
    check("u100_7_quot",    out_quot,      32'd14);
    check("u100_7_rem",     out_rem,       32'd2);
    check("u100_7_dbz",     32'(out_dbz),  32'd0);
    check("u100_7_tag",     32'(out_tag),  32'd5);
    consume();
    check("u100_7_released", 32'(busy), 32'd0);

    // Signed -7/2 and 7/-2.
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 5'd1);
    wait_result(lat);
    check("sm7_2_quot", out_quot, 32'hFFFF_FFFD);
    check("sm7_2_rem",  out_rem,  32'hFFFF_FFFF);
    consume();
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 5'd2);
    wait_result(lat);
    check("s7_m2_quot", out_quot, 32'hFFFF_FFFD);
    check("s7_m2_rem",  out_rem,  32'd1);
    consume();

    // Signed overflow MIN / -1.
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    wait_result(lat);
    check("smin_m1_quot", out_quot, 32'h8000_0000);
    check("smin_m1_rem",  out_rem,  32'd0);
    consume();

    // Unsigned 5/0: valid in the cycle right after the accept cycle.
    issue(1'b0, 32'd5, 32'd0, 5'd9);
    check("dbz_valid_next_cycle", 32'(out_valid), 32'd1);
    check("dbz_quot", out_quot,     32'hFFFF_FFFF);
    check("dbz_rem",  out_rem,      32'd5);
    check("dbz_flag", 32'(out_dbz), 32'd1);
    check("dbz_tag",  32'(out_tag), 32'd9);

    // Backpressure: hold the dbz result for 10 cycles.
    held_quot = out_quot;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid",    32'(out_valid), 32'd1);
      check("bp_quot",     out_quot,       held_quot);
      check("bp_in_ready", 32'(in_ready),  32'd0);
    end

    // Back-to-back: consume and accept a new operation in the same cycle.
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_signed   = 1'b0;
    in_dividend = 32'd1000;
    in_divisor  = 32'd10;
    in_tag      = 5'd3;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_valid_drop", 32'(out_valid), 32'd0);
    check("b2b_busy",       32'(busy),      32'd1);
    wait_result(lat);
    check("b2b_latency", 32'(lat),     32'd34);
    check("b2b_quot",    out_quot,     32'd100);
    check("b2b_rem",     out_rem,      32'd0);
    check("b2b_tag",     32'(out_tag), 32'd3);
    consume();

    // Flush at CALC cycle 15: result never appears.
    issue(1'b0, 32'd12345, 32'd11, 5'd7);
    repeat (15) @(posedge clk);
    #1;
    check("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_idle", 32'(busy), 32'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      seen_valid = seen_valid | out_valid;
    end
    check("flush_no_valid", 32'(seen_valid), 32'd0);

    // Flush with in_valid in IDLE blocks the accept.
    flush    = 1'b1;
    in_valid = 1'b1;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_not_accepted", 32'(busy), 32'd0);

    // Asynchronous reset mid-CALC; out_quot still holds 100 beforehand.
    issue(1'b0, 32'd999, 32'd9, 5'd6);
    repeat (10) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_busy",  32'(busy),      32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_quot",  out_quot,       32'd0);
    check("arst_tag",   32'(out_tag),   32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Radix-16 instance: 0xFFFFFFFF / 0x10 unsigned, 10 edges after accept.
    in_signed4   = 1'b0;
    in_dividend4 = 32'hFFFF_FFFF;
    in_divisor4  = 32'h0000_0010;
    in_tag4      = 5'd17;
    in_valid4    = 1'b1;
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("bpc4_latency", 32'(lat),      32'd10);
    check("bpc4_quot",    out_quot4,     32'h0FFF_FFFF);
    check("bpc4_rem",     out_rem4,      32'h0000_000F);
    check("bpc4_tag",     32'(out_tag4), 32'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
